// File: rtl/serial_receiver_pkg.sv
// Shared constants, receiver state encoding and bit-timing helper for the
// UART frame receiver.
package serial_receiver_pkg;

   localparam int FRAME_BYTES = 8;
   localparam int DATA_W      = 17;
   localparam int TS_W        = 24;
   localparam int ZERO_IDX_A  = 3;
   localparam int ZERO_IDX_B  = 7;
   localparam int MSB_IDX     = 2;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/serial_receiver_uart_rx.sv
// 8N1 UART byte receiver: rx synchroniser, mid-bit sampling timer and byte FSM.
// valid/frame_err are single-cycle strobes issued in the stop-bit sample cycle.
module serial_receiver_uart_rx
   import serial_receiver_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
   output rx_state_t  state
);

   localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
   localparam int TMR_W = $clog2(CPB + 1);
   localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CPB / 2);
   localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CPB - 1);

   logic             sync1_q, sync2_q, prev_q;
   rx_state_t        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tick;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // A held-low line leaves prev_q low, so re-arming needs a fresh 1->0 edge.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      valid     = 1'b0;
      frame_err = 1'b0;
      tick      = (tmr_q == '0);
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync2_q) begin
               tmr_d   = HALF_BIT;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (!tick) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else if (!sync2_q) begin
               tmr_d   = FULL_BIT;
               bit_d   = 3'd0;
               state_d = RX_DATA;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_DATA: begin
            if (!tick) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else begin
               shift_d = {sync2_q, shift_q[7:1]};
               tmr_d   = FULL_BIT;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (!tick) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else begin
               valid     = sync2_q;
               frame_err = !sync2_q;
               state_d   = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign data  = shift_q;
   assign busy  = (state_q != RX_IDLE);
   assign state = state_q;

endmodule

// File: rtl/serial_receiver.sv
// Frame assembler for the tracker's 8-byte UART frame: checks the zero fields,
// recovers decoded_data/timestamp and abandons partial frames after a line gap.
module serial_receiver
   import serial_receiver_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 115200,
   parameter int GAP_BITS = 20
) (
   input  logic              clk_12MHz,
   input  logic              rstn,
   input  logic              rx,
   output logic              data_valid,
   output logic [DATA_W-1:0] decoded_data,
   output logic [TS_W-1:0]   timestamp,
   output logic              frame_error,
   output logic              busy,
   output logic [2:0]        dbg_byte_idx,
   output logic [1:0]        dbg_rx_state
);

   localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
   localparam int GAP_LIMIT = GAP_BITS * CPB;
   localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   logic              rst_meta_q, rst_sync_q;
   logic [7:0]        rx_data;
   logic              rx_valid, rx_ferr, rx_busy;
   rx_state_t         rx_state;
   logic [2:0]        idx_q, idx_d;
   logic [DATA_W-1:0] stage_data_q, stage_data_d, out_data_q, out_data_d;
   logic [TS_W-1:0]   stage_ts_q, stage_ts_d, out_ts_q, out_ts_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              dv_q, dv_d, fe_q, fe_d;
   logic              check_fail, timeout;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk_12MHz or negedge rstn) begin
      if (!rstn) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   serial_receiver_uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_uart_rx (
      .clk       (clk_12MHz),
      .rstn      (rst_sync_q),
      .rx        (rx),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr),
      .busy      (rx_busy),
      .state     (rx_state)
   );

   always_ff @(posedge clk_12MHz or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         idx_q        <= '0;
         stage_data_q <= '0;
         stage_ts_q   <= '0;
         out_data_q   <= '0;
         out_ts_q     <= '0;
         gap_q        <= '0;
         dv_q         <= 1'b0;
         fe_q         <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         stage_data_q <= stage_data_d;
         stage_ts_q   <= stage_ts_d;
         out_data_q   <= out_data_d;
         out_ts_q     <= out_ts_d;
         gap_q        <= gap_d;
         dv_q         <= dv_d;
         fe_q         <= fe_d;
      end
   end

   always_comb begin
      idx_d        = idx_q;
      stage_data_d = stage_data_q;
      stage_ts_d   = stage_ts_q;
      out_data_d   = out_data_q;
      out_ts_d     = out_ts_q;
      gap_d        = gap_q;
      dv_d         = 1'b0;
      check_fail   = 1'b0;
      timeout      = 1'b0;

      if (rx_valid) begin
         case (idx_q)
            3'd0: stage_data_d[7:0]  = rx_data;
            3'd1: stage_data_d[15:8] = rx_data;
            3'(MSB_IDX): begin
               if (rx_data[7:1] != 7'd0) check_fail = 1'b1;
               else                      stage_data_d[16] = rx_data[0];
            end
            3'(ZERO_IDX_A), 3'(ZERO_IDX_B): check_fail = (rx_data != 8'h00);
            3'd4: stage_ts_d[7:0]   = rx_data;
            3'd5: stage_ts_d[15:8]  = rx_data;
            3'd6: stage_ts_d[23:16] = rx_data;
            default: ;
         endcase
         if (check_fail) begin
            idx_d = 3'd0;
         end else if (idx_q == LAST_IDX) begin
            out_data_d = stage_data_q;
            out_ts_d   = stage_ts_q;
            dv_d       = 1'b1;
            idx_d      = 3'd0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end

      if (rx_ferr) idx_d = 3'd0;

      // Leaving IDLE (a start edge) clears the gap count.
      if (idx_q != 3'd0 && rx_state == RX_IDLE) begin
         if (gap_q == GAP_W'(GAP_LIMIT - 1)) begin
            timeout = 1'b1;
            idx_d   = 3'd0;
            gap_d   = '0;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end else begin
         gap_d = '0;
      end

      fe_d = rx_ferr | check_fail | timeout;
   end

   assign data_valid   = dv_q;
   assign decoded_data = out_data_q;
   assign timestamp    = out_ts_q;
   assign frame_error  = fe_q;
   assign busy         = (idx_q != 3'd0) || rx_busy;
   assign dbg_byte_idx = idx_q;
   assign dbg_rx_state = rx_state;

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Host-side/loopback counterpart of the tracker's UART frame transmitter.
- Deserialises the 8-byte frame {decoded[7:0], decoded[15:8], decoded[23:16], 0x00, ts[7:0], ts[15:8], ts[23:16], 0x00} (8N1, LSB first) from a UART line.
- Validates the fixed zero fields, recovers decoded_data (17 b) and timestamp (24 b), and presents them with a one-cycle valid strobe.
- Used for bench loopback and for a second board consuming tracker output.

Parameters:
CLK_FREQ, 12000000, clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 104 at defaults)
GAP_BITS, 20, inter-byte idle time, in bit periods, after which a partial frame is abandoned

Ports:
clk_12MHz  input  1  system clock
rstn  input  1  asynchronous active-low reset
rx  input  1  UART line, idle high, asynchronous to clk_12MHz
data_valid  output  1  one-cycle pulse: new frame on decoded_data/timestamp
decoded_data  output  17  decoded word from last good frame
timestamp  output  24  timestamp from last good frame
frame_error  output  1  one-cycle pulse: byte or frame discarded
busy  output  1  high while byte_idx != 0 or a byte is being received

Behaviour:
- Reset: asynchronous assert, synchronous release internally. All outputs 0. byte_idx=0, timers=0, rx synchroniser preset to 1.
- rx passes through a 2-flop synchroniser before any use.
- Byte receiver FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a falling edge on synchronised rx loads the bit timer with CLKS_PER_BIT/2 and enters START.
  - START: at timer expiry rx must be 0, else false start, back to IDLE, no error. If 0, enter DATA.
  - DATA: sample 8 bits at each CLKS_PER_BIT expiry, LSB first.
  - STOP: sample one bit later. rx=1 gives a byte_valid pulse. rx=0 is a framing error: byte dropped, frame_error pulsed, byte_idx cleared. Return to IDLE either way; the next start edge is accepted from the cycle after STOP.
- Frame assembler, 3-bit byte_idx, acting on byte_valid:
  - idx 0, 1, 4, 5, 6: store byte into the staging register.
  - idx 2: byte[7:1] must be 0; bit0 becomes decoded[16].
  - idx 3 and idx 7: byte must be 0x00.
  - Any check failure: frame_error pulse, byte_idx <= 0, staging discarded, outputs unchanged.
  - idx 7 passing: on the edge after byte_valid, decoded_data and timestamp update and data_valid=1 for exactly one cycle. Outputs hold until the next good frame.
  - byte_idx wraps 7 -> 0 after a good frame.
- Latency: data_valid rises 1 cycle after the stop-bit sample of byte 7.
- Gap timeout:
  - Counter runs only when byte_idx != 0 and the receiver FSM is in IDLE. It clears on every start-edge detection.
  - Reaching GAP_BITS*CLKS_PER_BIT pulses frame_error and clears byte_idx. This resynchronises after a mid-frame start.
- Simultaneous events: byte_valid and timeout cannot coincide, because the timer is frozen outside IDLE. If a framing error and a check failure coincide, only one frame_error pulse is generated.
- Reset mid-byte or mid-frame: everything aborts, outputs clear. The first start edge after release begins a new frame at idx 0.
- A break condition (rx held low) produces a single framing error. The receiver then waits for rx=1 before re-arming.

Decomposition:
- Shared package/header:
  - FRAME_BYTES=8
  - DATA_W=17, TS_W=24
  - zero-field positions 3 and 7
  - receiver state encodings
  - a CLKS_PER_BIT helper
- Sub-module uart_rx holds the synchroniser, byte FSM and bit timer. It is the peer of the existing uart_tx: outputs data[7:0], valid, frame_err, busy; ports clk, rstn, rx.
- serial_receiver holds the frame assembler and gap timer.

Test Plan:
- Good frame: bytes CD AB 01 00 56 34 12 00 -> one data_valid pulse, decoded_data=0x1ABCD, timestamp=0x123456, no frame_error.
- Two back-to-back frames with zero inter-byte gap (second: FF FF 00 00 01 00 00 00) -> two data_valid pulses; final values 0x0FFFF and 0x000001.
- Byte 3 = 0x5A in an otherwise good frame -> frame_error after byte 3; outputs keep previous values. The following good frame is accepted.
- Byte 2 = 0x03 -> frame_error, no data_valid.
- Stop bit forced low on byte 1 -> frame_error, byte_idx=0. The next clean frame decodes correctly.
- Three bytes sent, then idle for 25 bit times, then a full good frame -> frame_error at 20*104 cycles after byte 2's stop sample, then one correct data_valid.
- rstn pulsed low during byte 5 -> outputs 0 immediately, busy=0. The next full frame decodes correctly.
- 0.5*CLKS_PER_BIT low glitch on idle rx -> no byte, no error.
